if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//  Sequences the IF stage against a variable-latency instruction memory (req/ack).
//  Drives PC enable/select and the IF stage register freeze/flush controls.
//  Holds one returned instruction while a data hazard stalls the pipe.
//  Kills in-flight fetches on a taken branch. Keeps stall and flush statistics.
// PARAMETERS
//  TIMEOUT  16  max cycles a request may wait for imem_ack before abort/retry (>=2)
//  CNT_W    16  width of the saturating statistics counters
// PORTS
//  clk            in   1      clock; all state updates on posedge
//  rst            in   1      synchronous reset, active-high
//  hazard         in   1      data hazard from hazard unit: IF must not advance
//  branch_taken   in   1      taken branch resolved in EXE this cycle
//  imem_ack       in   1      instruction memory: instr_in valid this cycle
//  instr_in       in   32     instruction word from memory
//  imem_req       out  1      request outstanding (Moore: state REQ or KILL)
//  imem_start     out  1      first cycle of a request; memory samples PC here
//  pc_en          out  1      PC register loads this cycle
//  pc_sel_branch  out  1      PC loads branch target (else PC+4); only with pc_en
//  if_reg_freeze  out  1      IF stage register holds
//  if_reg_flush   out  1      IF stage register clears (bubble)
//  instr_out      out  32     instruction to IF stage register
//  fetch_timeout  out  1      1-cycle pulse: request aborted after TIMEOUT cycles
//  stall_cnt      out  CNT_W  cycles with if_reg_freeze=1 outside IDLE, saturating
//  flush_cnt      out  CNT_W  cycles with if_reg_flush=1, saturating
// BEHAVIOUR
//  States: IDLE, REQ, HOLD, KILL. Reset -> IDLE, wait_cnt=0, buf=0, counters=0.
//  Defaults (all states): pc_en=0, pc_sel_branch=0, if_reg_flush=0,
//   if_reg_freeze=1, fetch_timeout=0, instr_out=instr_in. Outputs other than
//   imem_req are combinational from state + inputs (same-cycle response).
//  Priority inside any state: branch_taken > timeout > ack/hazard.
//  IDLE: imem_req=0; -> REQ next cycle, imem_start=1 there.
//  REQ:
//   - branch_taken: pc_en=1, pc_sel_branch=1, if_reg_flush=1, if_reg_freeze=0.
//     With ack: stay REQ, new start next cycle. Without ack: -> KILL.
//   - ack, !hazard: pc_en=1, if_reg_freeze=0; stay REQ, start next cycle.
//   - ack, hazard: buf<=instr_in, -> HOLD.
//   - no ack: wait_cnt++; at wait_cnt==TIMEOUT-1 pulse fetch_timeout, -> IDLE.
//  HOLD: imem_req=0, instr_out=buf.
//   - branch_taken: PC to target, flush, discard buf -> REQ.
//   - !hazard: pc_en=1, if_reg_freeze=0 (buf captured) -> REQ.
//   - hazard: stay.
//  KILL: imem_req=1, old fetch in flight, its data discarded.
//   - ack -> REQ, start next cycle. PC already holds the target.
//   - branch_taken: PC to target, flush; stay KILL (ack still pending).
//   - timeout: as in REQ, -> IDLE.
//  imem_start=1 exactly in the first REQ cycle after IDLE, HOLD or KILL, or after
//   a REQ cycle with ack. Never asserted on entry to KILL.
//  wait_cnt clears on every imem_start cycle and resets to 0 there.
//  hazard is ignored while no instruction has returned (REQ without ack, KILL).
//  Counters saturate at all-ones; they never wrap. rst mid-request drops
//   imem_req next cycle. The memory discards the unacked transaction.
// TESTING
//  Reset, ack every cycle -> imem_start cycle 1; pc_en=1, freeze=0 each cycle.
//  Ack after 3 wait cycles -> 3 freeze cycles, stall_cnt=3, pc_en one cycle.
//  Ack with hazard held 2 cycles -> HOLD; instr_out=held word (e.g. 32'hE3A01005)
//   for 2 cycles; released when hazard drops; no refetch.
//  branch_taken while waiting, ack 2 cycles later -> flush+pc_sel_branch once;
//   late data not passed; next imem_start after ack; flush_cnt=1.
//  No ack, TIMEOUT=16 -> fetch_timeout at wait cycle 16; 1 IDLE cycle; new start.
//  CNT_W=2, 5 flushes -> flush_cnt sticks at 3. rst in HOLD -> IDLE, buf cleared.

Source files
------------

// File: rtl/if_fetch_ctrl_if.sv
// Handshake bundle between the IF fetch controller and its environment:
// hazard/branch inputs, instruction memory handshake, IF stage controls and statistics.
interface if_fetch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             hazard;
    logic             branch_taken;
    logic             imem_ack;
    logic [31:0]      instr_in;
    logic             imem_req;
    logic             imem_start;
    logic             pc_en;
    logic             pc_sel_branch;
    logic             if_reg_freeze;
    logic             if_reg_flush;
    logic [31:0]      instr_out;
    logic             fetch_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  hazard, branch_taken, imem_ack, instr_in,
        output imem_req, imem_start, pc_en, pc_sel_branch, if_reg_freeze,
               if_reg_flush, instr_out, fetch_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        output hazard, branch_taken, imem_ack, instr_in,
        input  imem_req, imem_start, pc_en, pc_sel_branch, if_reg_freeze,
               if_reg_flush, instr_out, fetch_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF stage sequencer for a variable-latency instruction memory: PC/IF-register
// control, one-entry hold buffer for hazards, branch kill of in-flight fetches.
module if_fetch_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    if_fetch_ctrl_if.master bus
);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} state_t;

    state_t            state, state_nxt;
    logic              start_q, start_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [31:0]       buf_q;
    logic              capture;
    logic              timed_out;
    logic [CNT_W-1:0]  stall_q, flush_q;

    logic              pc_en, pc_sel_branch, if_reg_freeze, if_reg_flush, fetch_timeout;
    logic [31:0]       instr_out;

    assign timed_out = (wait_cnt == WAIT_MAX);

    // A taken branch redirects the PC and bubbles the IF register in every state;
    // the case below only decides where the sequencer goes next.
    always_comb begin
        state_nxt     = state;
        start_nxt     = 1'b0;
        capture       = 1'b0;
        pc_en         = 1'b0;
        pc_sel_branch = 1'b0;
        if_reg_flush  = 1'b0;
        if_reg_freeze = 1'b1;
        fetch_timeout = 1'b0;
        instr_out     = bus.instr_in;

        if (bus.branch_taken) begin
            pc_en         = 1'b1;
            pc_sel_branch = 1'b1;
            if_reg_flush  = 1'b1;
            if_reg_freeze = 1'b0;
        end

        case (state)
            IDLE: begin
                state_nxt = REQ;
                start_nxt = 1'b1;
            end
            REQ: begin
                if (bus.branch_taken) begin
                    if (bus.imem_ack) start_nxt = 1'b1;
                    else              state_nxt = KILL;
                end else if (bus.imem_ack) begin
                    if (bus.hazard) begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        pc_en         = 1'b1;
                        if_reg_freeze = 1'b0;
                        start_nxt     = 1'b1;
                    end
                end else if (timed_out) begin
                    fetch_timeout = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            HOLD: begin
                instr_out = buf_q;
                if (bus.branch_taken) begin
                    state_nxt = REQ;
                    start_nxt = 1'b1;
                end else if (!bus.hazard) begin
                    pc_en         = 1'b1;
                    if_reg_freeze = 1'b0;
                    state_nxt     = REQ;
                    start_nxt     = 1'b1;
                end
            end
            KILL: begin
                // The returning word belongs to the wrong path; only its ack matters.
                if (bus.imem_ack) begin
                    state_nxt = REQ;
                    start_nxt = 1'b1;
                end else if (!bus.branch_taken && timed_out) begin
                    fetch_timeout = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_q <= start_nxt;
        end
    end

    // Wait counter saturates so a branch at the last wait cycle still times out in KILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (start_nxt) begin
            wait_cnt <= '0;
        end else if ((state == REQ || state == KILL) && !bus.imem_ack && !timed_out) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
        end else if (capture) begin
            buf_q <= bus.instr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (if_reg_freeze && state != IDLE && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (if_reg_flush && flush_q != '1)                   flush_q <= flush_q + 1'b1;
        end
    end

    assign bus.imem_req      = (state == REQ) || (state == KILL);
    assign bus.imem_start    = (state == REQ) && start_q;
    assign bus.pc_en         = pc_en;
    assign bus.pc_sel_branch = pc_sel_branch;
    assign bus.if_reg_freeze = if_reg_freeze;
    assign bus.if_reg_flush  = if_reg_flush;
    assign bus.instr_out     = instr_out;
    assign bus.fetch_timeout = fetch_timeout;
    assign bus.stall_cnt     = stall_q;
    assign bus.flush_cnt     = flush_q;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed vector table, corner-case sequences and a
// random run against a transaction-level model; a 2-bit-counter copy checks saturation.
module tb_if_fetch_ctrl;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard = 1'b0;
    logic        branch_taken = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] instr_in = '0;

    int asserts  = 0;
    int failures = 0;

    if_fetch_ctrl_if #(.CNT_W(16)) bus16 ();
    if_fetch_ctrl_if #(.CNT_W(2))  bus2 ();

    assign bus16.hazard       = hazard;
    assign bus16.branch_taken = branch_taken;
    assign bus16.imem_ack     = imem_ack;
    assign bus16.instr_in     = instr_in;
    assign bus2.hazard        = hazard;
    assign bus2.branch_taken  = branch_taken;
    assign bus2.imem_ack      = imem_ack;
    assign bus2.instr_in      = instr_in;

    if_fetch_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    if_fetch_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    // Model: is a memory transaction open, is it doomed, is a word parked, how long waited.
    typedef struct packed {
        logic        start, req, pc_en, sel, flush, freeze, tout;
        logic [31:0] instr;
    } outs_t;

    bit          m_idle, m_busy, m_doomed, m_held, m_new;
    logic [31:0] m_word;
    int          m_age, m_stalls, m_flushes;

    task automatic modelReset();
        m_idle = 1; m_busy = 0; m_doomed = 0; m_held = 0; m_new = 0;
        m_word = '0; m_age = 0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic startReq();
        m_idle = 0; m_busy = 1; m_doomed = 0; m_new = 1; m_age = 0;
    endtask

    function automatic outs_t modelOut(bit h, bit b, bit a, logic [31:0] w);
        outs_t o;
        o.req   = m_busy;
        o.start = m_busy && m_new;
        o.instr = m_held ? m_word : w;
        o.pc_en = 0; o.sel = 0; o.flush = 0; o.tout = 0;
        if (b) begin
            o.pc_en = 1; o.sel = 1; o.flush = 1;
        end else if (m_busy && !a && m_age == TIMEOUT - 1) begin
            o.tout = 1;
        end else if ((m_busy && !m_doomed && a && !h) || (m_held && !h)) begin
            o.pc_en = 1;
        end
        o.freeze = !o.pc_en;
        return o;
    endfunction

    task automatic modelStep(bit h, bit b, bit a, logic [31:0] w, outs_t o);
        if (o.freeze && !m_idle) m_stalls++;
        if (o.flush) m_flushes++;
        if (m_idle) begin
            startReq();
        end else if (m_held) begin
            if (b || !h) begin
                m_held = 0;
                startReq();
            end
        end else if (m_busy) begin
            if (a) begin
                if (!m_doomed && !b && h) begin
                    m_busy = 0; m_held = 1; m_word = w;
                end else begin
                    startReq();
                end
            end else begin
                m_new = 0;
                if (b) begin
                    m_doomed = 1;
                    if (m_age < TIMEOUT - 1) m_age++;
                end else if (m_age == TIMEOUT - 1) begin
                    m_busy = 0; m_doomed = 0; m_idle = 1;
                end else begin
                    m_age++;
                end
            end
        end
    endtask

    function automatic int sat(int v, int max);
        return (v > max) ? max : v;
    endfunction

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
        asserts++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(bit h, bit b, bit a, logic [31:0] w);
        hazard = h; branch_taken = b; imem_ack = a; instr_in = w;
        #2;
    endtask

    // Compares the whole output set against the model, advances it, moves to next negedge.
    task automatic checkOutput();
        outs_t o;
        o = modelOut(hazard, branch_taken, imem_ack, instr_in);
        compare("imem_start",    bus16.imem_start,    o.start);
        compare("imem_req",      bus16.imem_req,      o.req);
        compare("pc_en",         bus16.pc_en,         o.pc_en);
        compare("pc_sel_branch", bus16.pc_sel_branch, o.sel);
        compare("if_reg_flush",  bus16.if_reg_flush,  o.flush);
        compare("if_reg_freeze", bus16.if_reg_freeze, o.freeze);
        compare("fetch_timeout", bus16.fetch_timeout, o.tout);
        compare("instr_out",     bus16.instr_out,     o.instr);
        compare("stall_cnt16",   bus16.stall_cnt,     32'(sat(m_stalls, 65535)));
        compare("flush_cnt16",   bus16.flush_cnt,     32'(sat(m_flushes, 65535)));
        compare("stall_cnt2",    bus2.stall_cnt,      32'(sat(m_stalls, 3)));
        compare("flush_cnt2",    bus2.flush_cnt,      32'(sat(m_flushes, 3)));
        modelStep(hazard, branch_taken, imem_ack, instr_in, o);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1; hazard = 0; branch_taken = 0; imem_ack = 0; instr_in = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        modelReset();
    endtask

    typedef struct {
        logic        h, b, a;
        logic [31:0] w;
        logic        start, req, pc_en, sel, flush, freeze;
        logic [31:0] instr;
        int          stall, fcnt;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // h b a  instr         | start req pc_en sel flush freeze instr_out     stall fcnt
        vecs[0]  = '{0,0,0,32'h0000_0000, 0,0,0,0,0,1,32'h0000_0000, 0,0};
        vecs[1]  = '{0,0,1,32'h0000_0011, 1,1,1,0,0,0,32'h0000_0011, 0,0};
        vecs[2]  = '{0,0,1,32'h0000_0022, 1,1,1,0,0,0,32'h0000_0022, 0,0};
        vecs[3]  = '{0,0,1,32'h0000_0033, 1,1,1,0,0,0,32'h0000_0033, 0,0};
        vecs[4]  = '{0,0,0,32'h0000_0044, 1,1,0,0,0,1,32'h0000_0044, 0,0};
        vecs[5]  = '{0,0,0,32'h0000_0055, 0,1,0,0,0,1,32'h0000_0055, 1,0};
        vecs[6]  = '{0,0,0,32'h0000_0066, 0,1,0,0,0,1,32'h0000_0066, 2,0};
        vecs[7]  = '{0,0,1,32'h0000_0077, 0,1,1,0,0,0,32'h0000_0077, 3,0};
        vecs[8]  = '{1,0,1,32'hE3A0_1005, 1,1,0,0,0,1,32'hE3A0_1005, 3,0};
        vecs[9]  = '{1,0,0,32'h0000_0000, 0,0,0,0,0,1,32'hE3A0_1005, 4,0};
        vecs[10] = '{0,0,0,32'h0000_0000, 0,0,1,0,0,0,32'hE3A0_1005, 5,0};
        vecs[11] = '{0,0,0,32'h0000_00BB, 1,1,0,0,0,1,32'h0000_00BB, 5,0};
        vecs[12] = '{0,1,0,32'h0000_00CC, 0,1,1,1,1,0,32'h0000_00CC, 6,0};
        vecs[13] = '{1,0,0,32'h0000_00DD, 0,1,0,0,0,1,32'h0000_00DD, 6,1};
        vecs[14] = '{0,0,1,32'hDEAD_BEEF, 0,1,0,0,0,1,32'hDEAD_BEEF, 7,1};
        vecs[15] = '{0,0,1,32'h0000_00FF, 1,1,1,0,0,0,32'h0000_00FF, 8,1};

        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].h, vecs[i].b, vecs[i].a, vecs[i].w);
            compare($sformatf("vec%0d_start", i),  bus16.imem_start,    vecs[i].start);
            compare($sformatf("vec%0d_req", i),    bus16.imem_req,      vecs[i].req);
            compare($sformatf("vec%0d_pc_en", i),  bus16.pc_en,         vecs[i].pc_en);
            compare($sformatf("vec%0d_sel", i),    bus16.pc_sel_branch, vecs[i].sel);
            compare($sformatf("vec%0d_flush", i),  bus16.if_reg_flush,  vecs[i].flush);
            compare($sformatf("vec%0d_freeze", i), bus16.if_reg_freeze, vecs[i].freeze);
            compare($sformatf("vec%0d_instr", i),  bus16.instr_out,     vecs[i].instr);
            compare($sformatf("vec%0d_stall", i),  bus16.stall_cnt,     32'(vecs[i].stall));
            compare($sformatf("vec%0d_fcnt", i),   bus16.flush_cnt,     32'(vecs[i].fcnt));
            checkOutput();
        end

        // Memory never answers: pulse on wait cycle TIMEOUT, one IDLE cycle, fresh start.
        doReset();
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput();
        for (int i = 1; i <= TIMEOUT; i++) begin
            applyStimulus(0, 0, 0, 32'h1000 + 32'(i));
            compare($sformatf("timeout_wait%0d", i), bus16.fetch_timeout, (i == TIMEOUT) ? 32'd1 : 32'd0);
            checkOutput();
        end
        applyStimulus(0, 0, 0, 32'h0);
        compare("timeout_idle_req", bus16.imem_req, 32'd0);
        checkOutput();
        applyStimulus(0, 0, 1, 32'h0);
        compare("timeout_restart", bus16.imem_start, 32'd1);
        checkOutput();

        // Five back-to-back branch flushes: the 2-bit counter sticks at 3.
        doReset();
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 1, 32'h2000 + 32'(i));
            checkOutput();
        end
        applyStimulus(0, 0, 1, 32'h0);
        compare("flush_sat2", bus2.flush_cnt, 32'd3);
        compare("flush_cnt16_5", bus16.flush_cnt, 32'd5);
        checkOutput();

        // Reset while parked in HOLD.
        doReset();
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput();
        applyStimulus(1, 0, 1, 32'h1234_5678);
        checkOutput();
        applyStimulus(1, 0, 0, 32'h0);
        compare("hold_word", bus16.instr_out, 32'h1234_5678);
        checkOutput();
        doReset();
        applyStimulus(1, 0, 0, 32'hA5A5_A5A5);
        compare("rst_hold_req", bus16.imem_req, 32'd0);
        compare("rst_hold_instr", bus16.instr_out, 32'hA5A5_A5A5);
        checkOutput();
        applyStimulus(1, 0, 0, 32'h0);
        compare("rst_hold_start", bus16.imem_start, 32'd1);
        checkOutput();

        // Random traffic against the model.
        doReset();
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 1,
                          $urandom_range(0, 9) < 4, $urandom);
            checkOutput();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
